sm83_irq_ctl: RTL and testbench
===============================

SM83_IRQ_CTL -- requirements
Module: sm83_irq_ctl

Interface
REQ-001 Parameter NUM_SRC, default 5: number of interrupt sources; valid range 1..8.
REQ-002 Parameter IF_ADR, default 16'hFF0F: address of the interrupt flag register (IF).
REQ-003 Parameter IE_ADR, default 16'hFFFF: address of the interrupt enable register (IE).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 adr  input  16  CPU address bus.
REQ-007 din  input  8  CPU write data.
REQ-008 rd  input  1  CPU read strobe, active-high level.
REQ-009 wr  input  1  CPU write strobe, active-high level.
REQ-010 dout  output  8  read data to CPU.
REQ-011 dout_oe  output  1  read data valid / drive enable.
REQ-012 req  input  NUM_SRC  peripheral request lines, synchronous to clk, rising-edge sensitive.
REQ-013 irq  output  8  pending and enabled interrupts to CPU; bit 0 is highest priority.
REQ-014 iack  input  8  CPU acknowledge; one bit per interrupt.
REQ-015 wake  output  1  HALT/STOP wake indication.

Function
REQ-016 IF SHALL be NUM_SRC bits; IE SHALL be a full 8-bit read/write register.
REQ-017 Request detection: IF[i] SHALL set in the cycle after req[i] transitions from 0 to 1, based on a registered previous req value; a held-high req SHALL NOT set IF again.
REQ-018 Write commit: one write per wr assertion, in the first cycle with wr=1 and wr=0 in the previous cycle, when adr equals IF_ADR or IE_ADR; remaining wr-high cycles SHALL be ignored.
REQ-019 IF write SHALL load din[NUM_SRC-1:0]; upper din bits are discarded.
REQ-020 IE write SHALL load din[7:0].
REQ-021 iack: IF[i] SHALL clear in the cycle after iack[i] rises from 0 to 1; every bit rising together SHALL clear; held iack SHALL NOT re-clear.
REQ-022 Same-cycle priority for each IF bit: bus write applied first, then iack clear, then request set. A new request edge wins over a simultaneous iack or write of 0.
REQ-023 irq[i] SHALL equal IF[i] & IE[i] for i < NUM_SRC, and 0 for i >= NUM_SRC; irq is combinational from registers.
REQ-024 wake SHALL equal |irq, independent of any CPU master enable.
REQ-025 Read: with rd=1, wr=0 and adr matching, dout/dout_oe SHALL be registered one cycle later; dout_oe SHALL stay 1 for as long as the qualifying rd persists.
REQ-026 IF read value SHALL be the IF bits, with all bits above NUM_SRC-1 reading as 1 (NUM_SRC=5 gives {3'b111, IF}).
REQ-027 IE read value SHALL be IE[7:0].
REQ-028 Non-matching address, rd=0, or rd and wr together: in the next cycle dout_oe=0 and dout=8'hFF; a simultaneous write still commits per REQ-018.
REQ-029 Read data SHALL reflect register contents at the sampling clock edge, before same-cycle updates.
REQ-030 If IF_ADR equals IE_ADR, behaviour is undefined; the bench does not exercise this case.

Reset
REQ-031 While reset=1: IF=0, IE=0, previous req/iack/wr registers=0, dout=8'hFF, dout_oe=0; irq=0 and wake=0 follow.
REQ-032 Reset SHALL take priority over all same-cycle writes, requests and acks.
REQ-033 A req held high across reset deassertion SHALL set IF in the first cycle after reset, since the previous req register is 0.
REQ-034 A wr held high across reset deassertion SHALL commit once.

Verification
REQ-035 Write IE=8'h1F, then pulse req[2] for 1 cycle -> IF=5'h04 next cycle; irq=8'h04; wake=1.
REQ-036 With IF=5'h05 and IE=8'h01, read IF_ADR -> dout=8'hE5 with dout_oe=1 one cycle after rd; irq=8'h01.
REQ-037 With IF[0]=1, iack[0] rises in the same cycle req[0] rises -> IF[0] stays 1; iack[0] rises alone -> IF[0]=0.
REQ-038 Hold wr=1 for 4 cycles at IF_ADR with din=8'hFF, while iack[1] rises in cycle 2 -> IF=5'h1F after cycle 1, IF[1]=0 after cycle 2, no re-write.
REQ-039 rd at adr=16'hFF10 -> dout=8'hFF, dout_oe=0; rd at IE_ADR after writing 8'hA5 -> dout=8'hA5.
REQ-040 Assert reset mid-operation with IF=5'h1F, IE=8'hFF and req[3] held high -> irq=0 and dout_oe=0; IF=5'h08 one cycle after reset drops.

Source files
------------

// File: rtl/sm83_irq_ctl.sv
// SM83-style interrupt controller: IF/IE registers on the CPU bus, edge-detected
// peripheral requests and acknowledges, prioritised irq vector and HALT/STOP wake.

module sm83_irq_flag (
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  logic wr_bit,
    input  logic ack_rise,
    input  logic req_rise,
    output logic flag
);
    logic flag_nxt;

    // Later assignments win: bus write, then ack clear, then a fresh request.
    always_comb begin
        flag_nxt = flag;
        if (wr_en)    flag_nxt = wr_bit;
        if (ack_rise) flag_nxt = 1'b0;
        if (req_rise) flag_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) flag <= 1'b0;
        else       flag <= flag_nxt;
    end
endmodule

module sm83_irq_ctl #(
    parameter int unsigned NUM_SRC = 5,
    parameter logic [15:0] IF_ADR  = 16'hFF0F,
    parameter logic [15:0] IE_ADR  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        adr,
    input  logic [7:0]         din,
    input  logic               rd,
    input  logic               wr,
    output logic [7:0]         dout,
    output logic               dout_oe,
    input  logic [NUM_SRC-1:0] req,
    output logic [7:0]         irq,
    input  logic [7:0]         iack,
    output logic               wake
);
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    typedef struct packed {
        logic       oe;
        logic [7:0] data;
    } rd_rsp_t;

    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] iack_q;
    logic               wr_q;
    logic [NUM_SRC-1:0] if_q;
    logic [7:0]         ie_q;
    rd_rsp_t            rsp_q;
    rd_rsp_t            rsp_nxt;

    logic [NUM_SRC-1:0] req_rise;
    logic [NUM_SRC-1:0] ack_rise;
    logic               wr_rise;
    logic               if_hit;
    logic               ie_hit;
    logic               if_wr;
    logic               ie_wr;
    logic               rd_hit;
    logic [7:0]         if_rd_val;
    logic [7:0]         iack_unused;

    // Acks for sources that do not exist have no flag to clear.
    assign iack_unused = iack & ~SRC_MASK;

    assign req_rise = req & ~req_q;
    assign ack_rise = iack[NUM_SRC-1:0] & ~iack_q;
    assign wr_rise  = wr & ~wr_q;
    assign if_hit   = (adr == IF_ADR);
    assign ie_hit   = (adr == IE_ADR);
    assign if_wr    = wr_rise & if_hit;
    assign ie_wr    = wr_rise & ie_hit;
    assign rd_hit   = rd & ~wr & (if_hit | ie_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= '0;
            iack_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            req_q  <= req;
            iack_q <= iack[NUM_SRC-1:0];
            wr_q   <= wr;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_flag
        sm83_irq_flag u_flag (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (if_wr),
            .wr_bit   (din[g]),
            .ack_rise (ack_rise[g]),
            .req_rise (req_rise[g]),
            .flag     (if_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)      ie_q <= 8'h00;
        else if (ie_wr) ie_q <= din;
    end

    // Unimplemented IF bits read back as 1.
    always_comb begin
        if_rd_val              = 8'hFF;
        if_rd_val[NUM_SRC-1:0] = if_q;
    end

    always_comb begin
        rsp_nxt.oe   = rd_hit;
        rsp_nxt.data = 8'hFF;
        if (rd_hit) rsp_nxt.data = if_hit ? if_rd_val : ie_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q.oe   <= 1'b0;
            rsp_q.data <= 8'hFF;
        end else begin
            rsp_q <= rsp_nxt;
        end
    end

    assign dout    = rsp_q.data;
    assign dout_oe = rsp_q.oe;

    always_comb begin
        irq              = 8'h00;
        irq[NUM_SRC-1:0] = if_q & ie_q[NUM_SRC-1:0];
    end

    // Wake ignores the CPU master enable so HALT exits even with IME clear.
    assign wake = |irq;
endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Scoreboard bench for sm83_irq_ctl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against irq/wake/dout/dout_oe.

module tb_sm83_irq_ctl;
    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [4:0]  req;
    logic [7:0]  irq;
    logic [7:0]  iack;
    logic        wake;

    typedef struct {
        int         at;
        logic [7:0] irq;
        logic       wake;
        logic       oe;
        string      name;
    } exp_t;

    exp_t       st_q[$];
    logic [7:0] rd_q[$];
    exp_t       e;
    logic [7:0] ev;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    sm83_irq_ctl dut (
        .clk     (clk),
        .reset   (reset),
        .adr     (adr),
        .din     (din),
        .rd      (rd),
        .wr      (wr),
        .dout    (dout),
        .dout_oe (dout_oe),
        .req     (req),
        .irq     (irq),
        .iack    (iack),
        .wake    (wake)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (st_q.size() > 0 && st_q[0].at <= cyc) begin
            e = st_q.pop_front();
            total++;
            if (irq !== e.irq) begin
                bad++;
                $display("FAIL %s irq got=%h want=%h", e.name, irq, e.irq);
            end
            total++;
            if (wake !== e.wake) begin
                bad++;
                $display("FAIL %s wake got=%b want=%b", e.name, wake, e.wake);
            end
            total++;
            if (dout_oe !== e.oe) begin
                bad++;
                $display("FAIL %s dout_oe got=%b want=%b", e.name, dout_oe, e.oe);
            end
            if (!e.oe) begin
                total++;
                if (dout !== 8'hFF) begin
                    bad++;
                    $display("FAIL %s idle dout got=%h want=ff", e.name, dout);
                end
            end
        end
        if (dout_oe === 1'b1) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_read dout=%h with no read pending", dout);
            end else begin
                ev = rd_q.pop_front();
                if (dout !== ev) begin
                    bad++;
                    $display("FAIL read_data got=%h want=%h", dout, ev);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input int dly, input logic [7:0] i, input logic w,
                             input logic o, input string n);
        exp_t x;
        x.at = cyc + dly; x.irq = i; x.wake = w; x.oe = o; x.name = n;
        st_q.push_back(x);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        adr = a; din = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
    endtask

    task automatic rd_reg(input logic [15:0] a, input logic [7:0] d);
        adr = a; rd = 1'b1;
        rd_q.push_back(d);
        tick();
        rd = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; adr = IF_A; din = 8'h00; rd = 1'b1; wr = 1'b0;
        req = 5'h1F; iack = 8'h00;

        // reset dominates requests and reads
        expect_st(1, 8'h00, 1'b0, 1'b0, "rst_a");
        tick();
        expect_st(1, 8'h00, 1'b0, 1'b0, "rst_b");
        tick();
        reset = 1'b0; req = 5'h00; rd = 1'b0;
        expect_st(1, 8'h00, 1'b0, 1'b0, "post_rst");
        tick();

        // IE=1F then one-cycle pulse on req[2]
        adr = IE_A; din = 8'h1F; wr = 1'b1;
        tick();
        wr = 1'b0; req = 5'h04;
        expect_st(1, 8'h04, 1'b1, 1'b0, "req2_set");
        tick();
        req = 5'h00;
        expect_st(1, 8'h04, 1'b1, 1'b0, "req2_hold");
        tick();
        rd_reg(IF_A, 8'hE4);

        // IF=05, IE=01, read IF held for two cycles
        wr_reg(IF_A, 8'h05);
        wr_reg(IE_A, 8'h01);
        expect_st(0, 8'h01, 1'b1, 1'b0, "ie01");
        adr = IF_A; rd = 1'b1;
        rd_q.push_back(8'hE5);
        tick();
        rd_q.push_back(8'hE5);
        expect_st(0, 8'h01, 1'b1, 1'b1, "rd_held");
        tick();
        rd = 1'b0;
        expect_st(1, 8'h01, 1'b1, 1'b0, "rd_drop");
        tick();

        // req edge beats simultaneous iack; lone iack clears; held iack does not re-clear
        iack = 8'h01; req = 5'h01;
        tick();
        iack = 8'h00; req = 5'h00;
        expect_st(0, 8'h01, 1'b1, 1'b0, "req_beats_ack");
        tick();
        iack = 8'h01;
        tick();
        expect_st(0, 8'h00, 1'b0, 1'b0, "ack_clears");
        wr_reg(IF_A, 8'h05);
        expect_st(0, 8'h01, 1'b1, 1'b0, "held_ack_no_clear");
        iack = 8'h00;
        rd_reg(IF_A, 8'hE5);

        // held wr commits once; iack[1] rise mid-hold clears
        wr_reg(IE_A, 8'hFF);
        adr = IF_A; din = 8'hFF; wr = 1'b1;
        tick();
        expect_st(0, 8'h1F, 1'b1, 1'b0, "wr_hold_c1");
        iack = 8'h02;
        tick();
        expect_st(0, 8'h1D, 1'b1, 1'b0, "wr_hold_c2");
        tick();
        expect_st(0, 8'h1D, 1'b1, 1'b0, "wr_hold_c3");
        tick();
        expect_st(0, 8'h1D, 1'b1, 1'b0, "wr_hold_c4");
        wr = 1'b0; iack = 8'h00;
        tick();
        rd_reg(IF_A, 8'hFD);

        // unmapped read, IE readback, rd+wr together
        adr = 16'hFF10; rd = 1'b1;
        expect_st(1, 8'h1D, 1'b1, 1'b0, "rd_unmapped");
        tick();
        rd = 1'b0;
        tick();
        wr_reg(IE_A, 8'hA5);
        expect_st(0, 8'h05, 1'b1, 1'b0, "iea5");
        rd_reg(IE_A, 8'hA5);
        adr = IE_A; din = 8'h3C; rd = 1'b1; wr = 1'b1;
        expect_st(1, 8'h1C, 1'b1, 1'b0, "rd_wr_both");
        tick();
        rd = 1'b0; wr = 1'b0;
        tick();
        rd_reg(IE_A, 8'h3C);

        // upper din bits dropped on IF write; read samples pre-update IF
        wr_reg(IF_A, 8'hE2);
        expect_st(0, 8'h00, 1'b0, 1'b0, "if_din_trunc");
        adr = IF_A; rd = 1'b1; req = 5'h10;
        rd_q.push_back(8'hE2);
        tick();
        rd_q.push_back(8'hF2);
        tick();
        rd = 1'b0; req = 5'h00;
        expect_st(1, 8'h10, 1'b1, 1'b0, "rd_before_update");
        tick();

        // reset mid-operation with req[3] and wr held across release
        wr_reg(IF_A, 8'h1F);
        wr_reg(IE_A, 8'hFF);
        expect_st(0, 8'h1F, 1'b1, 1'b0, "pre_rst");
        reset = 1'b1; req = 5'h08; adr = IE_A; din = 8'h08; wr = 1'b1;
        expect_st(1, 8'h00, 1'b0, 1'b0, "mid_rst_a");
        tick();
        expect_st(1, 8'h00, 1'b0, 1'b0, "mid_rst_b");
        tick();
        reset = 1'b0;
        expect_st(1, 8'h08, 1'b1, 1'b0, "post_rst_req3");
        tick();
        din = 8'hFF;
        expect_st(1, 8'h08, 1'b1, 1'b0, "post_rst_wr_once");
        tick();
        wr = 1'b0; req = 5'h00;
        tick();
        rd_reg(IE_A, 8'h08);
        rd_reg(IF_A, 8'hE8);

        for (int k = 0; k < 20 && (st_q.size() > 0 || rd_q.size() > 0); k++) tick();
        total++;
        if (st_q.size() != 0 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover st=%0d rd=%0d want=0", st_q.size(), rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
